// File: rtl/sifh_peak_finder_pkg.sv
// Shared sizing and FSM encoding for the SiFH per-pixel ToF peak finder.
package sifh_peak_finder_pkg;

  localparam int unsigned BIN_NUM_PER_HIS   = 16;
  localparam int unsigned PIXEL_NUM_PER_RAM = 4;
  localparam int unsigned PEAK_MAX          = 8;
  localparam int unsigned RAM_ADDR          = $clog2(BIN_NUM_PER_HIS * PIXEL_NUM_PER_RAM);
  localparam int unsigned NB                = $clog2(BIN_NUM_PER_HIS);
  localparam int unsigned NP = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;

  localparam logic [RAM_ADDR-1:0] LAST_ADDR =
      RAM_ADDR'(BIN_NUM_PER_HIS * PIXEL_NUM_PER_RAM - 1);
  localparam logic [NB-1:0]       LAST_BIN  = NB'(BIN_NUM_PER_HIS - 1);
  localparam logic [NP-1:0]       LAST_PIX  = NP'(PIXEL_NUM_PER_RAM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sifh_peak_finder_if.sv
// Control, RAM read port and result bundle of the peak finder.
interface sifh_peak_finder_if;
  import sifh_peak_finder_pkg::*;

  logic                start;
  logic [PEAK_MAX-1:0] thr;
  logic [RAM_ADDR-1:0] raddr;
  logic                rEnable;
  logic                readFlag;
  logic [PEAK_MAX-1:0] counts;
  logic                busy;
  logic                peak_valid;
  logic [NP-1:0]       peak_pixel;
  logic [NB-1:0]       peak_bin;
  logic [PEAK_MAX-1:0] peak_count;
  logic                peak_hit;
  logic                done;

  modport master (
    input  start, thr, counts,
    output raddr, rEnable, readFlag, busy,
    output peak_valid, peak_pixel, peak_bin, peak_count, peak_hit, done
  );

  modport slave (
    output start, thr, counts,
    input  raddr, rEnable, readFlag, busy,
    input  peak_valid, peak_pixel, peak_bin, peak_count, peak_hit, done
  );

endinterface

// File: rtl/sifh_max_tracker.sv
// Running argmax over one pixel's bins; result registers hold until the next last bin.
module sifh_max_tracker
  import sifh_peak_finder_pkg::*;
(
  input  logic                clk,
  input  logic                res,
  input  logic                in_valid,
  input  logic                first,
  input  logic                last,
  input  logic [NB-1:0]       bin,
  input  logic [PEAK_MAX-1:0] value,
  input  logic [PEAK_MAX-1:0] thr,
  output logic [PEAK_MAX-1:0] max,
  output logic [NB-1:0]       arg,
  output logic                hit,
  output logic                out_valid
);

  logic [PEAK_MAX-1:0] run_max, cand_max;
  logic [NB-1:0]       run_arg, cand_arg;
  logic                cand_hit;

  // Strictly greater keeps the lowest bin on ties.
  always_comb begin
    cand_max = run_max;
    cand_arg = run_arg;
    if (first) begin
      cand_max = value;
      cand_arg = '0;
    end else if (value > run_max) begin
      cand_max = value;
      cand_arg = bin;
    end
    cand_hit = (cand_max >= thr);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      run_max   <= '0;
      run_arg   <= '0;
      max       <= '0;
      arg       <= '0;
      hit       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid && last;
      if (in_valid) begin
        run_max <= cand_max;
        run_arg <= cand_arg;
      end
      if (in_valid && last) begin
        max <= cand_max;
        arg <= cand_hit ? cand_arg : '0;
        hit <= cand_hit;
      end
    end
  end

endmodule

// File: rtl/sifh_peak_finder.sv
// Sweeps the histogram RAM read port and reports the peak bin of every pixel.
module sifh_peak_finder
  import sifh_peak_finder_pkg::*;
(
  input logic               clk,
  input logic               res,
  sifh_peak_finder_if.master bus
);

  state_e              state;
  logic [RAM_ADDR-1:0] raddr_q;
  logic                ren_q;
  logic                busy_q;
  logic                drain_q;
  logic [PEAK_MAX-1:0] thr_q;

  logic                tag_valid;
  logic [NB-1:0]       tag_bin;
  logic [NP-1:0]       tag_pix;
  logic                tag_first, tag_last;

  logic [NP-1:0]       pixel_q;
  logic                done_q;

  logic [PEAK_MAX-1:0] trk_max;
  logic [NB-1:0]       trk_arg;
  logic                trk_hit, trk_valid;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      drain_q <= 1'b0;
      thr_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            thr_q   <= bus.thr;
            raddr_q <= '0;
            ren_q   <= 1'b1;
            busy_q  <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (raddr_q == LAST_ADDR) begin
            ren_q   <= 1'b0;
            drain_q <= 1'b0;
            state   <= DRAIN;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        DRAIN: begin
          // One cycle for the last read data, one for the result register.
          if (drain_q) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags travel with each read so they line up with counts one cycle later.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tag_valid <= 1'b0;
      tag_bin   <= '0;
      tag_pix   <= '0;
    end else begin
      tag_valid <= ren_q;
      tag_bin   <= raddr_q[NB-1:0];
      tag_pix   <= NP'(raddr_q >> NB);
    end
  end

  assign tag_first = (tag_bin == '0);
  assign tag_last  = (tag_bin == LAST_BIN);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pixel_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= tag_valid && tag_last && (tag_pix == LAST_PIX);
      if (tag_valid && tag_last) begin
        pixel_q <= tag_pix;
      end
    end
  end

  sifh_max_tracker u_tracker (
    .clk       (clk),
    .res       (res),
    .in_valid  (tag_valid),
    .first     (tag_first),
    .last      (tag_last),
    .bin       (tag_bin),
    .value     (bus.counts),
    .thr       (thr_q),
    .max       (trk_max),
    .arg       (trk_arg),
    .hit       (trk_hit),
    .out_valid (trk_valid)
  );

  assign bus.raddr      = raddr_q;
  assign bus.rEnable    = ren_q;
  assign bus.readFlag   = ren_q;
  assign bus.busy       = busy_q;
  assign bus.peak_valid = trk_valid;
  assign bus.peak_pixel = pixel_q;
  assign bus.peak_bin   = trk_arg;
  assign bus.peak_count = trk_max;
  assign bus.peak_hit   = trk_hit;
  assign bus.done       = done_q;

endmodule
